// File: rtl/ili9341_pkg.sv
// Shared constants for the ILI9341 display path: command codes, panel size,
// the default post-command delay and the SPI byte engine state encoding.
package ili9341_pkg;

    localparam logic [7:0] SWRESET    = 8'h01;
    localparam logic [7:0] SLPOUT     = 8'h11;
    localparam logic [7:0] DISPON     = 8'h29;
    localparam logic [7:0] SET_COLUMN = 8'h2A;
    localparam logic [7:0] SET_PAGE   = 8'h2B;
    localparam logic [7:0] WRITE_RAM  = 8'h2C;

    localparam int unsigned WIDTH  = 240;
    localparam int unsigned HEIGHT = 320;

    localparam int unsigned DELAY_DEFAULT = 2_700_000;
    localparam int unsigned WAIT_W        = 22;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DELAY = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/spi_delay_counter.sv
// Loadable down-counter with a zero flag; load has priority, otherwise it
// counts down and parks at zero.
module spi_delay_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/spi_byte_tx.sv
// SPI mode 0 byte serializer for the ILI9341: shifts one byte MSB first with
// its D/C flag, holds CS, optionally waits DELAY cycles, then pulses o_done.
module spi_byte_tx
    import ili9341_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HOLD = 1,
    parameter int unsigned DELAY   = DELAY_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    input  logic       i_we,
    input  logic       i_need_delay,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs,
    output logic       o_dc,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        dc_q, dc_d;
    logic        need_delay_q, need_delay_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic              half_load, half_zero;
    logic              wait_load, wait_zero;
    logic [WAIT_W-1:0] wait_val;
    logic              go_delay;

    spi_delay_counter #(.CNT_W(DIV_W)) u_half_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (half_load),
        .load_val (HALF_LOAD),
        .zero     (half_zero)
    );

    spi_delay_counter #(.CNT_W(WAIT_W)) u_wait_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (wait_load),
        .load_val (wait_val),
        .zero     (wait_zero)
    );

    assign go_delay = need_delay_q && (DELAY > 0);

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        dc_d         = dc_q;
        need_delay_d = need_delay_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        cs_d         = cs_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        half_load    = 1'b0;
        wait_load    = 1'b0;
        wait_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_we) begin
                    state_d      = ST_SHIFT;
                    data_d       = i_data;
                    dc_d         = i_dc;
                    need_delay_d = i_need_delay;
                    bit_cnt_d    = 3'd7;
                    mosi_d       = i_data[7];
                    sclk_d       = 1'b0;
                    cs_d         = 1'b0;
                    busy_d       = 1'b1;
                    half_load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_zero) begin
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        half_load = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != 3'd0) begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            mosi_d    = data_q[bit_cnt_q - 3'd1];
                            half_load = 1'b1;
                        end else if (CS_HOLD > 0) begin
                            state_d   = ST_HOLD;
                            wait_load = 1'b1;
                            wait_val  = WAIT_W'(CS_HOLD - 1);
                        end else begin
                            // No CS hold: release CS on the same edge the last bit ends
                            cs_d = 1'b1;
                            if (go_delay) begin
                                state_d   = ST_DELAY;
                                wait_load = 1'b1;
                                wait_val  = WAIT_W'(DELAY - 1);
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (wait_zero) begin
                    cs_d = 1'b1;
                    if (go_delay) begin
                        state_d   = ST_DELAY;
                        wait_load = 1'b1;
                        wait_val  = WAIT_W'(DELAY - 1);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (wait_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            dc_q         <= 1'b0;
            need_delay_q <= 1'b0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            dc_q         <= dc_d;
            need_delay_q <= need_delay_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_q         <= cs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_sclk = sclk_q;
    assign o_mosi = mosi_q;
    assign o_cs   = cs_q;
    assign o_dc   = dc_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Self-checking bench for spi_byte_tx: captured per-cycle waveforms are compared
// against an arithmetic timing model and an SCLK-edge byte decoder.
module tb_spi_byte_tx;

    localparam int CLK_DIV = 2;
    localparam int CS_HOLD = 1;
    localparam int DELAY   = 10;
    localparam int TSH     = 16 * CLK_DIV;
    localparam int LIMIT   = 200;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_dc = 1'b0;
    logic       i_we = 1'b0;
    logic       i_need_delay = 1'b0;
    logic       o_sclk, o_mosi, o_cs, o_dc, o_busy, o_done;

    int tests = 0;
    int fails = 0;

    // {sclk, mosi, cs, dc, busy, done} sampled 1 ns after each rising edge
    logic [5:0] cap [0:LIMIT];

    always #5 i_clk = ~i_clk;

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV),
        .CS_HOLD (CS_HOLD),
        .DELAY   (DELAY)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_dc         (i_dc),
        .i_we         (i_we),
        .i_need_delay (i_need_delay),
        .o_sclk       (o_sclk),
        .o_mosi       (o_mosi),
        .o_cs         (o_cs),
        .o_dc         (o_dc),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    function automatic int t_done(input logic nd);
        return 1 + TSH + CS_HOLD + (nd ? DELAY : 0);
    endfunction

    // Expected outputs in cycle n, with the accepting write in cycle 0
    function automatic logic [5:0] exp_vec(input int n, input logic [7:0] d,
                                           input logic dc, input logic nd);
        logic sclk, mosi, cs, busy, done;
        int idx;
        sclk = (n >= 1) && (n <= TSH) && (((n - 1) % (2 * CLK_DIV)) >= CLK_DIV);
        if (n <= TSH) begin
            idx  = (n - 1) / (2 * CLK_DIV);
            mosi = d[7 - idx];
        end else begin
            mosi = d[0];
        end
        cs   = !(n <= TSH + CS_HOLD);
        busy = (n <= t_done(nd));
        done = (n == t_done(nd));
        return {sclk, mosi, cs, dc, busy, done};
    endfunction

    // Returns {rising edge count, byte assembled from MOSI at each SCLK rise}
    function automatic logic [11:0] decode(input int last);
        int edges;
        logic [7:0] b;
        edges = 0;
        b = '0;
        for (int n = 2; n <= last; n++) begin
            if (cap[n][5] && !cap[n-1][5]) begin
                b = {b[6:0], cap[n][4]};
                edges++;
            end
        end
        return {4'(edges), b};
    endfunction

    // Issues a write in the current cycle, records cycles 1..done+tail;
    // optional stray writes with random data in cycles spur_a/spur_b.
    task automatic capture(input logic [7:0] d, input logic dc, input logic nd,
                           input int spur_a, input int spur_b, input int tail,
                           output int last);
        int done_at;
        done_at = -1;
        last = LIMIT;
        i_data = d;
        i_dc = dc;
        i_need_delay = nd;
        i_we = 1'b1;
        for (int n = 1; n <= LIMIT; n++) begin
            @(posedge i_clk);
            #1;
            cap[n] = {o_sclk, o_mosi, o_cs, o_dc, o_busy, o_done};
            i_data = 8'($urandom);
            i_dc = 1'($urandom);
            i_need_delay = 1'($urandom);
            i_we = (n == spur_a) || (n == spur_b);
            if (o_done && done_at < 0) done_at = n;
            if (done_at >= 0 && n >= done_at + tail) begin
                last = n;
                break;
            end
        end
        i_we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            i_data = 8'($urandom);
            i_dc = 1'($urandom);
            i_we = 1'($urandom);
            i_need_delay = 1'($urandom);
            @(posedge i_clk);
            #1;
            tests++;
            if ({o_sclk, o_mosi, o_cs, o_dc, o_busy, o_done} !== 6'b001000) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %b expected 001000", i,
                         {o_sclk, o_mosi, o_cs, o_dc, o_busy, o_done});
            end
        end
        i_we = 1'b0;
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            tests++;
            if ({o_sclk, o_cs, o_busy, o_done} !== 4'b0100) begin
                fails++;
                $display("FAIL reset_release[%0d]: sclk/cs/busy/done got %b expected 0100", i,
                         {o_sclk, o_cs, o_busy, o_done});
            end
        end
    endtask

    task automatic test_single_byte();
        int last;
        logic [11:0] dec;
        capture(8'hA5, 1'b1, 1'b0, -1, -1, 2, last);
        for (int n = 1; n <= last; n++) begin
            tests++;
            if (cap[n] !== exp_vec(n, 8'hA5, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL a5_wave cycle %0d: got %b expected %b", n, cap[n],
                         exp_vec(n, 8'hA5, 1'b1, 1'b0));
            end
        end
        dec = decode(last);
        tests++;
        if (dec !== {4'd8, 8'hA5}) begin
            fails++;
            $display("FAIL a5_decode: got edges=%0d byte=%h expected edges=8 byte=a5",
                     dec[11:8], dec[7:0]);
        end
        tests++;
        if (last !== 36) begin
            fails++;
            $display("FAIL a5_done_cycle: got %0d expected 34", last - 2);
        end
    endtask

    task automatic test_delay();
        int last;
        logic [11:0] dec;
        capture(8'h01, 1'b0, 1'b1, -1, -1, 2, last);
        for (int n = 1; n <= last; n++) begin
            tests++;
            if (cap[n] !== exp_vec(n, 8'h01, 1'b0, 1'b1)) begin
                fails++;
                $display("FAIL delay_wave cycle %0d: got %b expected %b", n, cap[n],
                         exp_vec(n, 8'h01, 1'b0, 1'b1));
            end
        end
        dec = decode(last);
        tests++;
        if (dec !== {4'd8, 8'h01}) begin
            fails++;
            $display("FAIL delay_decode: got edges=%0d byte=%h expected edges=8 byte=01",
                     dec[11:8], dec[7:0]);
        end
        tests++;
        if (last - 2 !== 44) begin
            fails++;
            $display("FAIL delay_done_cycle: got %0d expected 44", last - 2);
        end
    endtask

    task automatic test_ignore_we();
        int last, ndone;
        logic [7:0] d;
        logic [11:0] dec;
        d = 8'($urandom);
        capture(d, 1'b1, 1'b0, 5, 34, 5, last);
        ndone = 0;
        for (int n = 1; n <= last; n++) begin
            if (cap[n][0]) ndone++;
            tests++;
            if (cap[n] !== exp_vec(n, d, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL ignore_wave cycle %0d: got %b expected %b", n, cap[n],
                         exp_vec(n, d, 1'b1, 1'b0));
            end
        end
        dec = decode(last);
        tests++;
        if (dec !== {4'd8, d}) begin
            fails++;
            $display("FAIL ignore_decode: got edges=%0d byte=%h expected edges=8 byte=%h",
                     dec[11:8], dec[7:0], d);
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL ignore_done_count: got %0d expected 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int last;
        logic [11:0] dec;
        i_data = 8'($urandom);
        i_dc = 1'b1;
        i_need_delay = 1'b0;
        i_we = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge i_clk);
            #1;
            i_we = 1'b0;
        end
        tests++;
        if (o_cs !== 1'b0) begin
            fails++;
            $display("FAIL midreset_pre_cs: got %b expected 0", o_cs);
        end
        i_rst = 1'b0;
        #1;
        tests++;
        if ({o_sclk, o_cs, o_busy, o_done} !== 4'b0100) begin
            fails++;
            $display("FAIL midreset_async: sclk/cs/busy/done got %b expected 0100",
                     {o_sclk, o_cs, o_busy, o_done});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            tests++;
            if (o_done !== 1'b0) begin
                fails++;
                $display("FAIL midreset_no_done[%0d]: got %b expected 0", i, o_done);
            end
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        capture(8'h2C, 1'b0, 1'b0, -1, -1, 1, last);
        for (int n = 1; n <= last; n++) begin
            tests++;
            if (cap[n] !== exp_vec(n, 8'h2C, 1'b0, 1'b0)) begin
                fails++;
                $display("FAIL midreset_2c_wave cycle %0d: got %b expected %b", n, cap[n],
                         exp_vec(n, 8'h2C, 1'b0, 1'b0));
            end
        end
        dec = decode(last);
        tests++;
        if (dec !== {4'd8, 8'h2C}) begin
            fails++;
            $display("FAIL midreset_2c_decode: got edges=%0d byte=%h expected edges=8 byte=2c",
                     dec[11:8], dec[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        logic       dcs [5];
        int last;
        logic [11:0] dec;
        bytes = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF};
        dcs   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            capture(bytes[k], dcs[k], 1'b0, -1, -1, 1, last);
            for (int n = 1; n <= last; n++) begin
                tests++;
                if (cap[n] !== exp_vec(n, bytes[k], dcs[k], 1'b0)) begin
                    fails++;
                    $display("FAIL b2b[%0d]_wave cycle %0d: got %b expected %b", k, n, cap[n],
                             exp_vec(n, bytes[k], dcs[k], 1'b0));
                end
            end
            dec = decode(last);
            tests++;
            if (dec !== {4'd8, bytes[k]}) begin
                fails++;
                $display("FAIL b2b[%0d]_decode: got edges=%0d byte=%h expected edges=8 byte=%h",
                         k, dec[11:8], dec[7:0], bytes[k]);
            end
        end
    endtask

    task automatic test_random();
        int last;
        logic [7:0] d;
        logic dc, nd;
        logic [11:0] dec;
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            dc = 1'($urandom);
            nd = 1'($urandom);
            capture(d, dc, nd, -1, -1, 1, last);
            for (int n = 1; n <= last; n++) begin
                tests++;
                if (cap[n] !== exp_vec(n, d, dc, nd)) begin
                    fails++;
                    $display("FAIL rand[%0d]_wave cycle %0d: got %b expected %b", k, n, cap[n],
                             exp_vec(n, d, dc, nd));
                end
            end
            dec = decode(last);
            tests++;
            if (dec !== {4'd8, d}) begin
                fails++;
                $display("FAIL rand[%0d]_decode: got edges=%0d byte=%h expected edges=8 byte=%h",
                         k, dec[11:8], dec[7:0], d);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_delay();
        test_ignore_we();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
